// File: rtl/cam_buf_rd.sv
// cam_buf_rd: LCD raster reader for the camera ping-pong frame buffers.
// Optional colour-bar pattern on blank frames: define CAM_BUF_RD_TEST_PATTERN_EN.
module cam_buf_rd #(
   parameter int H_ACTIVE = 480,
   parameter int H_SYNC   = 41,
   parameter int H_BP     = 2,
   parameter int H_FP     = 2,
   parameter int V_ACTIVE = 272,
   parameter int V_SYNC   = 10,
   parameter int V_BP     = 2,
   parameter int V_FP     = 2
) (
   input  logic        iClk,
   input  logic        wRsn,
   input  logic        buf_sel_i,
   input  logic        buf0_full_i,
   input  logic        buf1_full_i,
   output logic        ram_rd_en_o,
   output logic [16:0] ram_rd_addr_o,
   output logic        ram_rd_buf_o,
   input  logic [15:0] ram_rd_data_i,
   output logic        lcd_hsync_o,
   output logic        lcd_vsync_o,
   output logic        lcd_de_o,
   output logic [15:0] lcd_rgb_o,
   output logic        rd_done_o,
   output logic [1:0]  dbg_state
);

   localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int HW      = (H_TOTAL > 2) ? $clog2(H_TOTAL) : 1;
   localparam int VW      = (V_TOTAL > 2) ? $clog2(V_TOTAL) : 1;

   localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_SYNC_END = HW'(H_SYNC);
   localparam logic [HW-1:0] H_ACT_BEG  = HW'(H_SYNC + H_BP);
   localparam logic [HW-1:0] H_ACT_END  = HW'(H_SYNC + H_BP + H_ACTIVE - 1);
   localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC);
   localparam logic [VW-1:0] V_ACT_BEG  = VW'(V_SYNC + V_BP);
   localparam logic [VW-1:0] V_ACT_END  = VW'(V_SYNC + V_BP + V_ACTIVE - 1);

   typedef enum logic [1:0] {
      F_WAIT   = 2'd0,
      F_ACTIVE = 2'd1,
      F_DONE   = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic [16:0]   pix_cnt;
   logic          have_frame;
   logic          reading;
   logic          cur_buf;
   logic          want_full;
   logic          hs_raw, vs_raw, h_act, v_act, active;
   logic          frame_start, last_pix;
   logic [15:0]   pat_raw;

   logic          hs_d1, vs_d1, de_d1;
   logic          hs_d2, vs_d2, de_d2, rd_d2;
   logic [15:0]   pat_d1, pat_d2;

   // Raster counters: sync, back porch, active, front porch in that order.
   always_ff @(posedge iClk or negedge wRsn) begin
      if (!wRsn) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
      end else begin
         h_cnt <= h_cnt + HW'(1);
      end
   end

   always_comb begin
      hs_raw      = (h_cnt >= H_SYNC_END);
      vs_raw      = (v_cnt >= V_SYNC_END);
      h_act       = (h_cnt >= H_ACT_BEG) && (h_cnt <= H_ACT_END);
      v_act       = (v_cnt >= V_ACT_BEG) && (v_cnt <= V_ACT_END);
      active      = h_act && v_act;
      frame_start = (h_cnt == '0) && (v_cnt == '0);
      last_pix    = (h_cnt == H_ACT_END) && (v_cnt == V_ACT_END);
      want_full   = buf_sel_i ? buf0_full_i : buf1_full_i;
   end

   // The buffer choice is frozen at frame start; flag changes later in the
   // frame wait for the next one.
   always_ff @(posedge iClk or negedge wRsn) begin
      if (!wRsn) begin
         cur_buf    <= 1'b0;
         have_frame <= 1'b0;
         reading    <= 1'b0;
      end else if (frame_start) begin
         if (want_full) begin
            cur_buf    <= ~buf_sel_i;
            have_frame <= 1'b1;
            reading    <= 1'b1;
         end else begin
            reading    <= have_frame;
         end
      end
   end

   always_ff @(posedge iClk or negedge wRsn) begin
      if (!wRsn) begin
         pix_cnt <= '0;
      end else if (frame_start) begin
         pix_cnt <= '0;
      end else if (active) begin
         pix_cnt <= pix_cnt + 17'd1;
      end
   end

   always_ff @(posedge iClk or negedge wRsn) begin
      if (!wRsn) state <= F_WAIT;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         F_WAIT:   if (active) state_nxt = last_pix ? F_DONE : F_ACTIVE;
         F_ACTIVE: if (last_pix) state_nxt = F_DONE;
         F_DONE:   state_nxt = F_WAIT;
         default:  state_nxt = F_WAIT;
      endcase
   end

   assign dbg_state    = state;
   assign ram_rd_buf_o = cur_buf;

`ifdef CAM_BUF_RD_TEST_PATTERN_EN
   localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
   int col, bar;
   always_comb begin
      col = int'(h_cnt) - (H_SYNC + H_BP);
      bar = col / BAR_W;
      case (bar)
         0:       pat_raw = 16'hFFFF;
         1:       pat_raw = 16'hFFE0;
         2:       pat_raw = 16'h07FF;
         3:       pat_raw = 16'h07E0;
         4:       pat_raw = 16'hF81F;
         5:       pat_raw = 16'hF800;
         6:       pat_raw = 16'h001F;
         default: pat_raw = 16'h0000;
      endcase
   end
`else
   assign pat_raw = 16'h0000;
`endif

   // Read handshake: ram_rd_en_o is a single-cycle request with no
   // backpressure; ram_rd_data_i must be valid exactly one clock later.
   always_ff @(posedge iClk or negedge wRsn) begin
      if (!wRsn) begin
         ram_rd_en_o   <= 1'b0;
         ram_rd_addr_o <= '0;
         rd_done_o     <= 1'b0;
         hs_d1         <= 1'b1;
         vs_d1         <= 1'b1;
         de_d1         <= 1'b0;
         pat_d1        <= '0;
      end else begin
         ram_rd_en_o <= active && reading;
         if (active && reading) ram_rd_addr_o <= pix_cnt;
         rd_done_o   <= (state == F_DONE) && reading;
         hs_d1       <= hs_raw;
         vs_d1       <= vs_raw;
         de_d1       <= active;
         pat_d1      <= (active && !reading) ? pat_raw : 16'h0000;
      end
   end

   // Stage 2 lines up with the returning RAM data, stage 3 drives the pins.
   always_ff @(posedge iClk or negedge wRsn) begin
      if (!wRsn) begin
         hs_d2       <= 1'b1;
         vs_d2       <= 1'b1;
         de_d2       <= 1'b0;
         rd_d2       <= 1'b0;
         pat_d2      <= '0;
         lcd_hsync_o <= 1'b1;
         lcd_vsync_o <= 1'b1;
         lcd_de_o    <= 1'b0;
         lcd_rgb_o   <= '0;
      end else begin
         hs_d2       <= hs_d1;
         vs_d2       <= vs_d1;
         de_d2       <= de_d1;
         rd_d2       <= ram_rd_en_o;
         pat_d2      <= pat_d1;
         lcd_hsync_o <= hs_d2;
         lcd_vsync_o <= vs_d2;
         lcd_de_o    <= de_d2;
         if (!de_d2)     lcd_rgb_o <= 16'h0000;
         else if (rd_d2) lcd_rgb_o <= ram_rd_data_i;
         else            lcd_rgb_o <= pat_d2;
      end
   end

endmodule

// File: tb/tb_cam_buf_rd.sv
// tb_cam_buf_rd: directed bench for cam_buf_rd at 8x4 active, 2-clock/2-line porches and syncs.
module tb_cam_buf_rd;

   localparam int FRAME = 140;   // 14 clocks/line * 10 lines

   logic        iClk = 1'b0;
   logic        wRsn = 1'b0;
   logic        buf_sel = 1'b0;
   logic        buf0_full = 1'b0;
   logic        buf1_full = 1'b0;
   logic        ram_rd_en;
   logic [16:0] ram_rd_addr;
   logic        ram_rd_buf;
   logic [15:0] ram_rd_data;
   logic        lcd_hsync, lcd_vsync, lcd_de;
   logic [15:0] lcd_rgb;
   logic        rd_done;
   logic [1:0]  dbg_state;

   int errors = 0;
   int checks = 0;
   int cyc;

   logic [15:0] exp_q[$];
   int          exp_t[$];

   typedef struct {
      int   t;
      logic hs;
      logic vs;
      logic de;
      int   col;
   } vec_t;
   vec_t vecs[13];

   cam_buf_rd #(
      .H_ACTIVE(8), .H_SYNC(2), .H_BP(2), .H_FP(2),
      .V_ACTIVE(4), .V_SYNC(2), .V_BP(2), .V_FP(2)
   ) dut (
      .iClk         (iClk),
      .wRsn         (wRsn),
      .buf_sel_i    (buf_sel),
      .buf0_full_i  (buf0_full),
      .buf1_full_i  (buf1_full),
      .ram_rd_en_o  (ram_rd_en),
      .ram_rd_addr_o(ram_rd_addr),
      .ram_rd_buf_o (ram_rd_buf),
      .ram_rd_data_i(ram_rd_data),
      .lcd_hsync_o  (lcd_hsync),
      .lcd_vsync_o  (lcd_vsync),
      .lcd_de_o     (lcd_de),
      .lcd_rgb_o    (lcd_rgb),
      .rd_done_o    (rd_done),
      .dbg_state    (dbg_state)
   );

   // clock / reset-relative cycle counter
   always #5 iClk = ~iClk;

   always @(posedge iClk or negedge wRsn) begin
      if (!wRsn) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   // RAM model: one-clock read latency, data tagged with buffer and address
   always @(posedge iClk) begin
      ram_rd_data <= ram_rd_en ? {ram_rd_buf, ram_rd_addr[14:0]} : 16'hDEAD;
   end

   function automatic logic [15:0] blank_rgb(input int col);
`ifdef CAM_BUF_RD_TEST_PATTERN_EN
      case (col)
         0:       return 16'hFFFF;
         1:       return 16'hFFE0;
         2:       return 16'h07FF;
         3:       return 16'h07E0;
         4:       return 16'hF81F;
         5:       return 16'hF800;
         6:       return 16'h001F;
         default: return 16'h0000;
      endcase
`else
      return (col >= 0) ? 16'h0000 : 16'h0000;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic wait_cyc(input int t);
      int guard = 0;
      while (cyc < t && guard < 4 * FRAME) begin
         @(negedge iClk);
         guard++;
      end
      checks++;
      if (cyc != t) begin
         errors++;
         $display("FAIL wait_cyc: reached cyc %0d expected %0d", cyc, t);
      end
   endtask

   // Watches one frame window: scoreboards every read against the pixel
   // that must appear 2 clocks later, and totals reads, DE and done pulses.
   task automatic run_frame(input int f, input logic exp_rd, input logic exp_buf, input int act);
      int n_rd = 0, n_de = 0, n_done = 0, last_rd = -100, done_at = -1, col = 0, guard = 0;
      logic [15:0] exp_v;
      exp_q.delete();
      exp_t.delete();
      while (cyc < FRAME * f + FRAME - 1 && guard < 2 * FRAME) begin
         @(negedge iClk);
         guard++;
         if (cyc == FRAME * f + 70) begin
            case (act)
               1: begin buf1_full = 1'b1; buf_sel = 1'b0; end
               2: begin buf0_full = 1'b0; buf1_full = 1'b0; end
               default: ;
            endcase
         end
         if (ram_rd_en) begin
            check("rd_addr", 32'(ram_rd_addr), 32'(n_rd));
            check("rd_buf", 32'(ram_rd_buf), 32'(exp_buf));
            exp_q.push_back({exp_buf, 15'(n_rd)});
            exp_t.push_back(cyc + 2);
            n_rd++;
            last_rd = cyc;
         end
         if (rd_done) begin
            n_done++;
            done_at = cyc;
         end
         if (exp_t.size() > 0 && exp_t[0] == cyc) begin
            void'(exp_t.pop_front());
            exp_v = exp_q.pop_front();
            check("pix_de", 32'(lcd_de), 32'd1);
            check("pix_rgb", 32'(lcd_rgb), 32'(exp_v));
            n_de++;
            col++;
         end else if (lcd_de) begin
            check("blank_rgb", 32'(lcd_rgb), 32'(blank_rgb(col)));
            n_de++;
            col++;
         end else begin
            check("idle_rgb", 32'(lcd_rgb), 32'd0);
            col = 0;
         end
      end
      checks++;
      if (guard >= 2 * FRAME) begin
         errors++;
         $display("FAIL frame_window f=%0d: ended at cyc %0d", f, cyc);
      end
      check("n_reads", 32'(n_rd), exp_rd ? 32'd32 : 32'd0);
      check("n_de", 32'(n_de), 32'd32);
      check("n_done", 32'(n_done), exp_rd ? 32'd1 : 32'd0);
      if (exp_rd) check("done_timing", 32'(done_at), 32'(last_rd + 1));
      check("queue_empty", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      // Outputs in cycle t show counter value c = t-3 (h = c%14, v = c/14).
      vecs[0]  = '{1,   1'b1, 1'b1, 1'b0, -1};
      vecs[1]  = '{3,   1'b0, 1'b0, 1'b0, -1};
      vecs[2]  = '{4,   1'b0, 1'b0, 1'b0, -1};
      vecs[3]  = '{5,   1'b1, 1'b0, 1'b0, -1};
      vecs[4]  = '{31,  1'b0, 1'b1, 1'b0, -1};
      vecs[5]  = '{33,  1'b1, 1'b1, 1'b0, -1};
      vecs[6]  = '{62,  1'b1, 1'b1, 1'b0, -1};
      vecs[7]  = '{63,  1'b1, 1'b1, 1'b1, 0};
      vecs[8]  = '{64,  1'b1, 1'b1, 1'b1, 1};
      vecs[9]  = '{70,  1'b1, 1'b1, 1'b1, 7};
      vecs[10] = '{71,  1'b1, 1'b1, 1'b0, -1};
      vecs[11] = '{108, 1'b1, 1'b1, 1'b1, 3};
      vecs[12] = '{115, 1'b0, 1'b1, 1'b0, -1};

      repeat (3) @(negedge iClk);
      check("rst_hsync", 32'(lcd_hsync), 32'd1);
      check("rst_vsync", 32'(lcd_vsync), 32'd1);
      check("rst_de", 32'(lcd_de), 32'd0);
      check("rst_rgb", 32'(lcd_rgb), 32'd0);
      check("rst_rd_en", 32'(ram_rd_en), 32'd0);
      check("rst_addr", 32'(ram_rd_addr), 32'd0);
      check("rst_buf", 32'(ram_rd_buf), 32'd0);
      check("rst_done", 32'(rd_done), 32'd0);
      check("rst_state", 32'(dbg_state), 32'd0);
      wRsn = 1'b1;

      // Frame 0: no flags, blank frame with normal timing
      for (int i = 0; i < 13; i++) begin
         wait_cyc(vecs[i].t);
         check("vec_hsync", 32'(lcd_hsync), 32'(vecs[i].hs));
         check("vec_vsync", 32'(lcd_vsync), 32'(vecs[i].vs));
         check("vec_de", 32'(lcd_de), 32'(vecs[i].de));
         check("vec_rgb", 32'(lcd_rgb), 32'(blank_rgb(vecs[i].col)));
         check("vec_rd_en", 32'(ram_rd_en), 32'd0);
      end

      run_frame(1, 1'b0, 1'b0, 0);
      buf_sel   = 1'b1;
      buf0_full = 1'b1;
      run_frame(2, 1'b1, 1'b0, 1);   // mid-frame: buf1 full, writer flips
      run_frame(3, 1'b1, 1'b1, 2);   // mid-frame: both flags dropped
      run_frame(4, 1'b1, 1'b1, 0);   // repeats buffer 1

      // Asynchronous reset in the middle of an active line
      wait_cyc(5 * FRAME + 66);
      check("pre_reset_de", 32'(lcd_de), 32'd1);
      buf_sel   = 1'b1;
      buf0_full = 1'b1;
      #1 wRsn = 1'b0;
      #1;
      check("async_hsync", 32'(lcd_hsync), 32'd1);
      check("async_vsync", 32'(lcd_vsync), 32'd1);
      check("async_de", 32'(lcd_de), 32'd0);
      check("async_rgb", 32'(lcd_rgb), 32'd0);
      check("async_rd_en", 32'(ram_rd_en), 32'd0);
      repeat (2) @(negedge iClk);
      wRsn = 1'b1;
      wait_cyc(2);
      check("restart_hs_pre", 32'(lcd_hsync), 32'd1);
      wait_cyc(3);
      check("restart_hs_low", 32'(lcd_hsync), 32'd0);
      check("restart_vs_low", 32'(lcd_vsync), 32'd0);
      run_frame(0, 1'b1, 1'b0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
